// File: rtl/arb_pkg.sv
// Shared types and sizes for the one-hot round-robin arbiter slice.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int HOLD_W = 4;
  localparam int PTR_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_t;

  // Grant is always one-hot when this is called, so the last set bit is the only one.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request strictly after ptr, wrapping 3->0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // The candidate index wraps naturally in PTR_W bits, so ptr itself is searched last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant, hold limit
// and a mandatory one-cycle gap between grants.
module onehot_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             timeout
);

  arb_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PTR_W-1:0]  ptr;
  logic [N_REQ-1:0]  winner;
  logic              owner_req;
  logic              hold_limit;
  logic              release_now;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner)
  );

  assign owner_req   = |(req & grant);
  assign hold_limit  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_now = done || !owner_req;

  // A voluntary release wins over the hold limit, so timeout only fires on a pure hold-limit exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= PTR_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            state    <= GRANT;
            grant    <= winner;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now || hold_limit) begin
            state    <= GAP;
            grant    <= '0;
            busy     <= 1'b0;
            ptr      <= onehot_to_idx(grant);
            timeout  <= !release_now;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        GAP: begin
          state   <= IDLE;
          timeout <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          busy     <= 1'b0;
          timeout  <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed scoreboard checks of the round-robin arbiter followed by a
// randomized run checking one-hot grant, busy and bounded waiting.
module tb_onehot_rr_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int WAIT_MAX = 3 * (MAX_HOLD + 2);

  typedef struct packed {
    logic [3:0] grant;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   wait_cnt[4];
  bit   waiting[4];

  onehot_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Pops the oldest expectation and compares all three outputs against it.
  task automatic checkOutput(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    total++;
    assert (grant === e.grant) else begin
      bad++;
      $error("[TB] FAIL %s grant: observed=%b expected=%b", tag, grant, e.grant);
    end
    total++;
    assert (busy === (e.grant != 4'b0000)) else begin
      bad++;
      $error("[TB] FAIL %s busy: observed=%b expected=%b", tag, busy, (e.grant != 4'b0000));
    end
    total++;
    assert (timeout === e.timeout) else begin
      bad++;
      $error("[TB] FAIL %s timeout: observed=%b expected=%b", tag, timeout, e.timeout);
    end
  endtask

  // Drives one cycle of inputs, queues the outputs expected after the edge, then checks them.
  task automatic applyStimulus(input logic [3:0] r, input logic d,
                               input logic [3:0] eg, input logic et, input string tag);
    @(negedge clk);
    req  = r;
    done = d;
    sb_q.push_back(exp_t'{grant: eg, timeout: et});
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [3:0] rr_seq[5];
    rr_seq[0] = 4'b0001;
    rr_seq[1] = 4'b0010;
    rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000;
    rr_seq[4] = 4'b0001;

    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(exp_t'{grant: 4'b0000, timeout: 1'b0});
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] round-robin rotation with done pulses");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 1'b0, rr_seq[k], 1'b0, "rr_grant");
      applyStimulus(4'b1111, 1'b1, 4'b0000, 1'b0, "rr_done_exit");
      applyStimulus(4'b1111, 1'b0, 4'b0000, 1'b0, "rr_gap");
    end
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "idle_no_req");

    $display("[TB] hold limit timeout");
    for (int k = 0; k < MAX_HOLD; k++)
      applyStimulus(4'b0100, 1'b0, 4'b0100, 1'b0, "hold_grant");
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b1, "hold_timeout");
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, "hold_gap_idle");
    applyStimulus(4'b0100, 1'b0, 4'b0100, 1'b0, "hold_regrant");
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "drop_exit");
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "drop_gap");

    $display("[TB] done coinciding with hold limit");
    for (int k = 0; k < MAX_HOLD; k++)
      applyStimulus(4'b0010, 1'b0, 4'b0010, 1'b0, "coinc_grant");
    applyStimulus(4'b0010, 1'b1, 4'b0000, 1'b0, "coinc_exit");
    applyStimulus(4'b0010, 1'b0, 4'b0000, 1'b0, "coinc_gap");
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "coinc_idle");

    $display("[TB] owner drops request with another pending");
    applyStimulus(4'b0001, 1'b0, 4'b0001, 1'b0, "drop_grant0");
    applyStimulus(4'b1001, 1'b0, 4'b0001, 1'b0, "nonowner_change");
    applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b0, "owner_drop_exit");
    applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b0, "owner_drop_gap");
    applyStimulus(4'b1000, 1'b0, 4'b1000, 1'b0, "pending_grant3");
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "g3_exit");
    applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, "done_in_gap");
    applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, "done_in_idle");

    $display("[TB] asynchronous reset mid-grant");
    applyStimulus(4'b0100, 1'b0, 4'b0100, 1'b0, "pre_reset_grant");
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(exp_t'{grant: 4'b0000, timeout: 1'b0});
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    sb_q.push_back(exp_t'{grant: 4'b0000, timeout: 1'b0});
    checkOutput("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0101;
    done  = 1'b0;
    sb_q.push_back(exp_t'{grant: 4'b0001, timeout: 1'b0});
    @(posedge clk);
    #1;
    checkOutput("post_reset_pick");

    $display("[TB] randomized run");
    for (int i = 0; i < 4; i++) begin
      wait_cnt[i] = 0;
      waiting[i]  = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(15) == 0) req[i] = ~req[i];
      done = ($urandom_range(7) == 0);
      @(posedge clk);
      #1;
      total++;
      assert ((grant & (grant - 4'd1)) === 4'b0000) else begin
        bad++;
        $error("[TB] FAIL rand_onehot: observed=%b expected=onehot_or_zero", grant);
      end
      total++;
      assert (busy === (grant != 4'b0000)) else begin
        bad++;
        $error("[TB] FAIL rand_busy: observed=%b expected=%b", busy, (grant != 4'b0000));
      end
      // Waiting is counted from the first cycle another requester visibly holds the grant.
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !grant[i]) begin
          if (grant != 4'b0000) waiting[i] = 1'b1;
          if (waiting[i]) wait_cnt[i]++;
        end else begin
          waiting[i]  = 1'b0;
          wait_cnt[i] = 0;
        end
        if (waiting[i]) begin
          total++;
          assert (wait_cnt[i] <= WAIT_MAX) else begin
            bad++;
            $error("[TB] FAIL rand_wait req%0d: observed=%0d expected<=%0d", i, wait_cnt[i], WAIT_MAX);
            wait_cnt[i] = 0;
            waiting[i]  = 1'b0;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one grant may be held (legal range 2..15).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  4  level request, one bit per requester; any combination legal.
REQ-006 Port: done  input  1  the current owner releases the grant; sampled only in GRANT.
REQ-007 Port: grant  output  4  registered grant; always 4'b0000 or exactly one bit set; feeds the 4-to-2 one-hot encoder.
REQ-008 Port: busy  output  1  registered; 1 exactly when grant != 0.
REQ-009 Port: timeout  output  1  registered one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT, GAP.
REQ-011 IDLE: grant=0; if req != 0 at a rising edge, the next state is GRANT and grant is loaded with the winner in the same edge; latency from req to grant is 1 cycle.
REQ-012 The winner SHALL be the first set req bit, searching upward from (ptr+1) mod 4 and wrapping 3->0.
REQ-013 GRANT: grant is held constant; hold_cnt increments by 1 per cycle, starting at 0 on the grant edge.
REQ-014 GRANT exits to GAP at the edge where done=1, or req[owner]=0, or hold_cnt==MAX_HOLD-1; grant clears at that edge.
REQ-015 Timeout: on a hold-limit exit, timeout=1 for exactly the first GAP cycle.
REQ-016 Simultaneous exit causes: done or a dropped req takes precedence over the hold limit, so timeout stays 0.
REQ-017 On every GRANT exit, ptr SHALL be loaded with the owner index, so the owner has lowest priority next round.
REQ-018 GAP: grant=0 for exactly one cycle, req is ignored, and the next state is IDLE; the minimum grant-to-grant spacing is therefore 2 idle cycles.
REQ-019 done asserted in IDLE or GAP SHALL be ignored.
REQ-020 In GRANT, req changes on non-owner bits SHALL have no effect.
REQ-021 hold_cnt is 4 bits wide and SHALL never wrap, because the exit occurs at MAX_HOLD-1.

Reset
REQ-022 While rst_n=0, the block SHALL hold state=IDLE, grant=4'b0000, busy=0, timeout=0, hold_cnt=0, ptr=2'd3.
REQ-023 Reset asserted mid-GRANT SHALL clear grant asynchronously, with no GAP cycle and no timeout pulse.
REQ-024 After rst_n deasserts, the first arbitration SHALL favour req[0].

Structure
REQ-025 The shared package arb_pkg SHALL hold the state enum (IDLE, GRANT, GAP), N_REQ=4, and the hold-counter width.
REQ-026 The rotating priority search SHALL be the combinational sub-module rr_pick (inputs: req, ptr; output: one-hot winner). The FSM, counter and pointer SHALL remain in onehot_rr_arbiter.

Verification
REQ-027 Reset release, then req=4'b1111 held with done pulsed 1 cycle after each grant: the grant sequence SHALL be 0001, 0010, 0100, 1000, 0001, with 2 zero cycles between grants.
REQ-028 req=4'b0100 held, done=0, MAX_HOLD=8: grant=0100 for exactly 8 cycles, then timeout=1 for 1 cycle; the next grant is 0100 again, 2 cycles later.
REQ-029 In GRANT on 0010, done=1 in the same cycle hold_cnt==MAX_HOLD-1: the exit occurs and timeout stays 0.
REQ-030 Owner 0001 drops req[0] while req=4'b1000 is pending: grant clears the next edge, and grant=1000 follows after the GAP and IDLE cycles.
REQ-031 rst_n pulled low mid-GRANT (grant=0100): grant=0 immediately (asynchronously); after release with req=4'b0101, the first grant is 0001.
REQ-032 A randomized 10k-cycle run SHALL check every cycle that grant is one-hot or zero, that busy == (grant != 0), and that no requester waits more than 3*(MAX_HOLD+2) cycles while its req is held.
